// File: rtl/speaker_tone_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : speaker_tone_arbiter
// Brief   : Round-robin owner of the differential speaker pair; plays one
//           latched tone per grant, then holds a silent gap.
// Revision: 1.0 - initial release
// ============================================================================
module speaker_tone_arbiter #(
  parameter int NREQ       = 3,
  parameter int DIV_W      = 16,
  parameter int DUR_W      = 24,
  parameter int GAP_CYCLES = 250000,
  localparam int ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DIV_W-1:0]   div,
  input  logic [NREQ*DUR_W-1:0]   dur,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [ID_W-1:0]         active_id,
  output logic                    spkp,
  output logic                    spkm
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] c_GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TONE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_rr;
  logic [ID_W-1:0]   r_id;
  logic [NREQ-1:0]   r_ack;
  logic [NREQ-1:0]   r_done;
  logic              r_busy;
  logic              r_spkp;
  logic              r_spkm;
  logic              r_lvl;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_half;
  logic [DUR_W-1:0]  r_cnt;
  logic [GAP_W-1:0]  r_gap;

  logic              w_found;
  logic [ID_W-1:0]   w_gnt;
  logic [DIV_W-1:0]  w_div_g;
  logic [DUR_W-1:0]  w_dur_g;
  logic              w_tone_last;
  logic              w_gap_last;
  logic              w_div_nz;

  // First set request at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req[(int'(r_rr) + i) % NREQ]) begin
        w_found = 1'b1;
        w_gnt   = ID_W'((int'(r_rr) + i) % NREQ);
      end
    end
  end

  assign w_div_g     = div[int'(w_gnt)*DIV_W +: DIV_W];
  assign w_dur_g     = dur[int'(w_gnt)*DUR_W +: DUR_W];
  assign w_tone_last = (r_cnt == '0);
  assign w_gap_last  = (r_gap == '0);
  assign w_div_nz    = |r_div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_found) w_state_nxt = S_TONE;
      S_TONE: if (w_tone_last) w_state_nxt = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      S_GAP:  if (w_gap_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr   <= '0;
      r_id   <= '0;
      r_ack  <= '0;
      r_done <= '0;
      r_busy <= 1'b0;
      r_spkp <= 1'b0;
      r_spkm <= 1'b0;
      r_lvl  <= 1'b0;
      r_div  <= '0;
      r_half <= '0;
      r_cnt  <= '0;
      r_gap  <= '0;
    end else begin
      r_ack  <= '0;
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_ack  <= NREQ'(1) << w_gnt;
            r_id   <= w_gnt;
            r_rr   <= (w_gnt == ID_W'(NREQ - 1)) ? '0 : w_gnt + ID_W'(1);
            r_busy <= 1'b1;
            r_div  <= w_div_g;
            r_half <= w_div_g - DIV_W'(1);
            r_cnt  <= (w_dur_g == '0) ? '0 : w_dur_g - DUR_W'(1);
            r_lvl  <= 1'b1;
            r_spkp <= |w_div_g;
            r_spkm <= 1'b0;
          end
        end
        S_TONE: begin
          if (w_tone_last) begin
            r_done <= NREQ'(1) << r_id;
            r_spkp <= 1'b0;
            r_spkm <= 1'b0;
            r_gap  <= c_GAP_LOAD;
            r_busy <= (GAP_CYCLES > 0);
          end else begin
            r_cnt <= r_cnt - DUR_W'(1);
            if (r_half == '0) begin
              r_lvl  <= ~r_lvl;
              r_half <= r_div - DIV_W'(1);
              r_spkp <= w_div_nz & ~r_lvl;
              r_spkm <= w_div_nz & r_lvl;
            end else begin
              r_half <= r_half - DIV_W'(1);
            end
          end
        end
        S_GAP: begin
          if (w_gap_last) r_busy <= 1'b0;
          else            r_gap  <= r_gap - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign ack       = r_ack;
  assign done      = r_done;
  assign busy      = r_busy;
  assign active_id = r_id;
  assign spkp      = r_spkp;
  assign spkm      = r_spkm;

endmodule
`default_nettype wire

// File: tb/tb_speaker_tone_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_speaker_tone_arbiter
// Brief   : Scoreboard bench; one instance with a 4-cycle gap, one with none.
// Revision: 1.0 - initial release
// ============================================================================
module tb_speaker_tone_arbiter;

  localparam int NREQ  = 3;
  localparam int DIV_W = 16;
  localparam int DUR_W = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req = '0, req_ng = '0;
  logic [NREQ*DIV_W-1:0] div = '0, div_ng = '0;
  logic [NREQ*DUR_W-1:0] dur = '0, dur_ng = '0;
  logic [NREQ-1:0]       ack, done, ack_ng, done_ng;
  logic                  busy, spkp, spkm, busy_ng, spkp_ng, spkm_ng;
  logic [1:0]            active_id, active_id_ng;

  speaker_tone_arbiter #(.NREQ(NREQ), .DIV_W(DIV_W), .DUR_W(DUR_W), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req(req), .div(div), .dur(dur),
    .ack(ack), .done(done), .busy(busy), .active_id(active_id),
    .spkp(spkp), .spkm(spkm)
  );

  speaker_tone_arbiter #(.NREQ(NREQ), .DIV_W(DIV_W), .DUR_W(DUR_W), .GAP_CYCLES(0)) dut_ng (
    .clk(clk), .rst(rst), .req(req_ng), .div(div_ng), .dur(dur_ng),
    .ack(ack_ng), .done(done_ng), .busy(busy_ng), .active_id(active_id_ng),
    .spkp(spkp_ng), .spkm(spkm_ng)
  );

  typedef struct {
    string      tag;
    logic [10:0] v;
  } exp_t;

  exp_t q[$];
  exp_t q_ng[$];
  exp_t e_m, e_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Record layout: {ack[2:0], done[2:0], busy, active_id[1:0], spkp, spkm}
  function automatic logic [10:0] pack(input logic [2:0] a, input logic [2:0] d, input logic b,
                                       input logic [1:0] id, input logic p, input logic m);
    return {a, d, b, id, p, m};
  endfunction

  task automatic push_rec(input int which, input string tag, input logic [10:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    if (which == 0) q.push_back(e);
    else            q_ng.push_back(e);
  endtask

  // Expected outputs from the ack cycle through the first idle cycle after the tone.
  task automatic push_tone(input int which, input string tag, input int g, input int d,
                           input int u, input int gap);
    int         len;
    logic [2:0] oh;
    logic       lvl;
    len = (u == 0) ? 1 : u;
    oh  = 3'b001 << g;
    for (int k = 0; k < len; k++) begin
      lvl = (d != 0) && (((k / d) % 2) == 0);
      push_rec(which, tag, pack((k == 0) ? oh : 3'b000, 3'b000, 1'b1, 2'(g), lvl, (d != 0) && !lvl));
    end
    for (int k = 0; k < gap; k++)
      push_rec(which, tag, pack(3'b000, (k == 0) ? oh : 3'b000, 1'b1, 2'(g), 1'b0, 1'b0));
    push_rec(which, tag, pack(3'b000, (gap == 0) ? oh : 3'b000, 1'b0, 2'(g), 1'b0, 1'b0));
  endtask

  task automatic drain(input int which, input int budget);
    int n;
    n = 0;
    while ((((which == 0) ? q.size() : q_ng.size()) > 0) && (n < budget)) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_value((which == 0) ? "drain" : "drain_ng", (which == 0) ? q.size() : q_ng.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && q.size() > 0) begin
      e_m = q.pop_front();
      check_value(e_m.tag, {21'b0, ack, done, busy, active_id, spkp, spkm}, {21'b0, e_m.v});
    end
  end

  always @(negedge clk) begin
    if (!rst && q_ng.size() > 0) begin
      e_n = q_ng.pop_front();
      check_value(e_n.tag, {21'b0, ack_ng, done_ng, busy_ng, active_id_ng, spkp_ng, spkm_ng},
                  {21'b0, e_n.v});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on: reset asserted between edges must clear outputs immediately.
    #3 rst = 1'b1;
    #1 check_value("por_async", {ack, done, busy, active_id, spkp, spkm}, 11'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) push_rec(0, "idle", 11'd0);
    drain(0, 20);

    // Fairness: all three held, grants rotate 0,1,2,0,1, acks 9 cycles apart.
    div = {16'd2, 16'd2, 16'd2};
    dur = {24'd4, 24'd4, 24'd4};
    push_tone(0, "rr_g0", 0, 2, 4, 4);
    push_tone(0, "rr_g1", 1, 2, 4, 4);
    push_tone(0, "rr_g2", 2, 2, 4, 4);
    push_tone(0, "rr_g0b", 0, 2, 4, 4);
    push_tone(0, "rr_g1b", 1, 2, 4, 4);
    req = 3'b111;
    repeat (37) @(negedge clk);
    #1 req = 3'b000;
    drain(0, 40);

    // Single tone: div=3, dur=12.
    div[0*DIV_W +: DIV_W] = 16'd3;
    dur[0*DUR_W +: DUR_W] = 24'd12;
    push_tone(0, "single", 0, 3, 12, 4);
    req = 3'b001;
    @(negedge clk);
    #1 req = 3'b000;
    drain(0, 40);

    // Silent tone: div=0.
    div[2*DIV_W +: DIV_W] = 16'd0;
    dur[2*DUR_W +: DUR_W] = 24'd5;
    push_tone(0, "div0", 2, 0, 5, 4);
    req = 3'b100;
    @(negedge clk);
    #1 req = 3'b000;
    drain(0, 40);

    // dur=0 behaves as a one-cycle tone.
    div[1*DIV_W +: DIV_W] = 16'd1;
    dur[1*DUR_W +: DUR_W] = 24'd0;
    push_tone(0, "dur0", 1, 1, 0, 4);
    req = 3'b010;
    @(negedge clk);
    #1 req = 3'b000;
    drain(0, 40);

    // Inputs changed after the grant must not affect the tone.
    div[1*DIV_W +: DIV_W] = 16'd2;
    dur[1*DUR_W +: DUR_W] = 24'd8;
    push_tone(0, "latch", 1, 2, 8, 4);
    req = 3'b010;
    @(negedge clk);
    #1 req = 3'b000;
    div[1*DIV_W +: DIV_W] = 16'd7;
    dur[1*DUR_W +: DUR_W] = 24'd2;
    drain(0, 40);

    // No-gap instance: one idle cycle (carrying done) between back-to-back tones.
    div_ng = {16'd0, 16'd1, 16'd1};
    dur_ng = {24'd0, 24'd3, 24'd3};
    push_tone(1, "nogap_g0", 0, 1, 3, 0);
    push_tone(1, "nogap_g1", 1, 1, 3, 0);
    req_ng = 3'b011;
    repeat (5) @(negedge clk);
    #1 req_ng = 3'b000;
    drain(1, 40);

    // Reset in the third tone cycle: immediate silence, no done afterwards.
    div[1*DIV_W +: DIV_W] = 16'd2;
    dur[1*DUR_W +: DUR_W] = 24'd10;
    push_rec(0, "pre_rst", pack(3'b010, 3'b000, 1'b1, 2'd1, 1'b1, 1'b0));
    push_rec(0, "pre_rst", pack(3'b000, 3'b000, 1'b1, 2'd1, 1'b1, 1'b0));
    req = 3'b010;
    @(negedge clk);
    #1 req = 3'b000;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_value("rst_mid_tone", {ack, done, busy, active_id, spkp, spkm}, 11'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) push_rec(0, "post_rst_idle", 11'd0);
    drain(0, 20);

    div[2*DIV_W +: DIV_W] = 16'd2;
    dur[2*DUR_W +: DUR_W] = 24'd3;
    push_tone(0, "after_rst", 2, 2, 3, 4);
    req = 3'b100;
    @(negedge clk);
    #1 req = 3'b000;
    drain(0, 40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/speaker_tone_arbiter.md
Name: speaker_tone_arbiter

Overview:
- Shares the single differential piezo/speaker pair (spkp/spkm) between NREQ independent tone requesters; runs after the 25 MHz PLL clock domain.
- Each requester asks for one tone: a half-period divisor plus a duration. The block arbitrates round-robin, generates the square wave, and signals completion.
- Inserts a fixed silent gap between tones so consecutive beeps stay audibly distinct.
- Replaces per-module free-running counter-MSB drivers with one sequenced owner of the speaker.

Parameters:
- NREQ, 3: number of requesters (2..8).
- DIV_W, 16: width of the half-period divisor, in clk cycles.
- DUR_W, 24: width of the tone duration, in clk cycles.
- GAP_CYCLES, 250000: silent gap after each tone (10 ms at 25 MHz); 0 disables the gap.

Ports:
- clk  input  1  system clock (25 MHz PLL output).
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  level request, one bit per requester.
- div  input  NREQ*DIV_W  half-period per requester, slice i = [i*DIV_W +: DIV_W].
- dur  input  NREQ*DUR_W  tone length per requester, slice i = [i*DUR_W +: DUR_W].
- ack  output  NREQ  one-cycle grant pulse.
- done  output  NREQ  one-cycle completion pulse.
- busy  output  1  high from grant until the end of the gap.
- active_id  output  clog2(NREQ) (min 1)  index of the current owner.
- spkp  output  1  speaker positive.
- spkm  output  1  speaker negative.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; rr pointer=0.
  - ack, done, busy, active_id, spkp and spkm all 0, effective immediately without waiting for an edge.
- States:
  - IDLE -> TONE on any req bit set.
  - TONE -> GAP when the duration expires (GAP_CYCLES>0).
  - TONE -> IDLE when the duration expires (GAP_CYCLES=0).
  - GAP -> IDLE after GAP_CYCLES cycles.
- Arbitration (IDLE only):
  - Search req starting at the rr pointer, wrapping modulo NREQ; the first set bit g wins.
  - At the clock edge: state=TONE, ack[g]=1 for exactly one cycle, active_id=g, busy=1, rr=(g+1) mod NREQ.
  - div[g] and dur[g] are latched at this edge; later input changes are ignored until the next grant.
- Request protocol:
  - req is level-sensitive.
  - A requester drops req after seeing ack; if held, it is re-arbitrated in round-robin order.
  - req changes during TONE/GAP have no effect until IDLE.
- Tone generation:
  - lvl=1 on entry; half counter loads div-1.
  - Each TONE cycle: if half==0, toggle lvl and reload div-1; else decrement.
  - Result: lvl holds div cycles high, div cycles low, and so on.
  - spkp=lvl and spkm=~lvl, registered, during TONE only.
- div=0: silent tone. spkp=spkm=0 for the whole duration; the rest of the timing is unchanged.
- Duration:
  - TONE lasts exactly max(dur,1) cycles; dur=0 behaves as 1.
  - On the last TONE cycle, done[active_id] pulses for one cycle, aligned with the first cycle where outputs are silent.
- Silent states: outside TONE, spkp=spkm=0. No DC is ever driven across the speaker.
- GAP: lasts exactly GAP_CYCLES cycles; busy stays 1; busy drops on entry to IDLE.
- Minimum spacing: at least one IDLE cycle separates two tones.
- ack and done never pulse in the same cycle.
- At most one ack bit and one done bit are high at any time.
- Reset mid-TONE or mid-GAP: outputs go to 0 at once; no done is issued; the pending tone is lost.

Test Plan:
- Bench uses GAP_CYCLES=4, NREQ=3.
- Power-on: rst=1 mid-cycle, then release -> all outputs 0; idle with req=0 keeps spkp=spkm=0 indefinitely.
- Single tone: req[0]=1 with div=3, dur=12, req dropped after ack -> ack[0] one cycle, then spkp=1,1,1,0,0,0,1,1,1,0,0,0 with spkm its complement. Then done[0] pulses once, outputs 0, busy 1 for 4 cycles, then 0.
- Fairness: req=3'b111 held, div=2, dur=4 each -> grant order 0,1,2,0,1. Each tone is 4 cycles followed by a 4-cycle gap plus 1 IDLE cycle, so consecutive acks are 9 cycles apart.
- Edge values:
  - div=0, dur=5 -> spkp=spkm=0 for 5 cycles, busy=1, done pulses.
  - dur=0, div=1 -> 1-cycle tone with spkp=1, then done.
- Latch and no-gap check: change div[1] mid-tone -> waveform unchanged. Rebuild with GAP_CYCLES=0 -> IDLE directly after TONE; busy low for exactly 1 cycle between back-to-back requests.
- Async reset: assert rst in the 3rd TONE cycle -> spkp=spkm=busy=0 before the next edge. No done is issued. After release, a req[2]-only request is granted with active_id=2.
